// File: rtl/load_store_unit.sv
// Memory-access stage: runs one aligned data-memory transaction per start over a req/ack bus,
// with byte-lane steering, load sign/zero extension and misaligned/illegal/timeout fault reporting.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    state_t        state;
    bus_t          bus_q;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [1:0]    off_q;

    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic          illegal;
    logic          misal;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_ext;

    assign mem_we    = bus_q.we;
    assign mem_addr  = bus_q.addr;
    assign mem_be    = bus_q.be;
    assign mem_wdata = bus_q.wdata;

    assign illegal = (MemOp > 3'b100) || (MemWr && MemOp[0]);
    assign misal   = (MemOp[2:1] == 2'b01 && addr[0]) ||
                     (MemOp == 3'b100 && addr[1:0] != 2'b00);

    always_comb begin
        be_n = 4'b0000;
        wd_n = '0;
        case (MemOp)
            3'b000, 3'b001: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{wdata[7:0]}};
            end
            3'b010, 3'b011: begin
                be_n = 4'b0011 << {addr[1], 1'b0};
                wd_n = {2{wdata[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = wdata;
            end
        endcase
        if (!MemWr) wd_n = '0;
    end

    // Extraction uses the offset/op captured at start, not the live inputs.
    always_comb begin
        byte_v   = mem_rdata[{off_q, 3'b000} +: 8];
        half_v   = mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (op_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {24'b0, byte_v};
            3'b010:  load_ext = {{16{half_v[15]}}, half_v};
            3'b011:  load_ext = {16'b0, half_v};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            fault   <= 2'b00;
            mem_req <= 1'b0;
            bus_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        op_q  <= MemOp;
                        off_q <= addr[1:0];
                        if (illegal) begin
                            state <= ERR;
                            done  <= 1'b1;
                            fault <= 2'b11;
                        end else if (misal) begin
                            state <= ERR;
                            done  <= 1'b1;
                            fault <= 2'b01;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            bus_q   <= '{we: MemWr, addr: {addr[31:2], 2'b00},
                                         be: be_n, wdata: wd_n};
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!bus_q.we) rdata <= load_ext;
                        state   <= DONE;
                        done    <= 1'b1;
                        fault   <= 2'b00;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        state   <= ERR;
                        done    <= 1'b1;
                        fault   <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
